// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared types and lane-order helper for the boot ROM loader
package boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROM_RD,
        ROM_CAP,
        WAIT_REQ,
        WRITE,
        IO_COLLECT,
        IO_FLUSH,
        DONE
    } state_e;

    typedef enum logic {
        SRC_ROM   = 1'b0,
        SRC_IOCTL = 1'b1
    } src_e;

    // Byte lane a stream byte lands in: little-endian fills from lane 0 up,
    // big-endian places the first byte in the most significant lane.
    function automatic int lane_of(input int idx, input int bytes, input bit big_endian);
        return big_endian ? (bytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles bytes into a BYTES-wide word with lane ordering and PAD fill
module byte_packer
    import boot_loader_pkg::*;
#(
    parameter int         BYTES      = 2,
    parameter bit         BIG_ENDIAN = 1'b0,
    parameter logic [7:0] PAD        = 8'hFF,
    localparam int        IW         = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [7:0]           byte_i,
    input  logic                 pad_i,
    output logic [8*BYTES-1:0]   word_o,
    output logic [IW-1:0]        idx_o,
    output logic                 last_o
);

    logic [8*BYTES-1:0] word_q, word_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW:0]        fill;

    // A byte and a pad request in the same cycle: the byte is stored first,
    // then every lane at or above the advanced index is padded.
    always_comb begin
        word_d = word_q;
        fill   = {1'b0, idx_q};
        if (load_i) begin
            word_d[8*lane_of(int'(idx_q), BYTES, BIG_ENDIAN) +: 8] = byte_i;
            fill = fill + (IW+1)'(1);
        end
        if (pad_i) begin
            for (int i = 0; i < BYTES; i++) begin
                if (i >= int'(fill)) begin
                    word_d[8*lane_of(i, BYTES, BIG_ENDIAN) +: 8] = PAD;
                end
            end
        end
        idx_d = (pad_i || fill == (IW+1)'(BYTES)) ? '0 : fill[IW-1:0];
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o = word_q;
    assign idx_o  = idx_q;
    assign last_o = (idx_q == IW'(BYTES - 1));

endmodule

// File: rtl/boot_rom_loader.sv
// rtl/boot_rom_loader.sv - copies a ROM or ioctl byte stream into the BIOS shadow; BOOT_ROM_LOADER_CHECKSUM_EN adds csum
module boot_rom_loader
    import boot_loader_pkg::*;
#(
    parameter int         BYTES      = 2,
    parameter int         TAW        = 13,
    parameter int         WORDS      = 8192,
    parameter bit         BIG_ENDIAN = 1'b0,
    parameter logic [7:0] PAD        = 8'hFF
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         src_sel,
    output logic                         rom_ce,
    output logic [TAW+$clog2(BYTES)-1:0] rom_addr,
    input  logic [7:0]                   rom_data,
    input  logic                         ioctl_download,
    input  logic                         ioctl_wr,
    input  logic [7:0]                   ioctl_dout,
    output logic                         ioctl_wait,
    input  logic                         tgt_req,
    output logic                         tgt_wr,
    output logic [TAW-1:0]               tgt_addr,
    output logic [8*BYTES-1:0]           tgt_din,
    output logic                         busy,
    output logic                         loaded,
    output logic                         overflow,
    output logic [TAW:0]                 words_loaded
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]                  csum,
    input  logic [15:0]                  csum_expect,
    output logic                         csum_ok
`endif
);

    localparam int           RAW     = TAW + $clog2(BYTES);
    localparam int           IW      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [TAW:0] WORDS_W = (TAW+1)'(WORDS);

    state_e         state_q, state_d;
    src_e           src_q, src_d;
    logic [TAW:0]   words_q, words_d;
    logic           ovf_q, ovf_d;
    logic           fin_q, fin_d;
    logic           dl_q;
    logic           fall;

    logic           pk_clear, pk_load, pk_pad, pk_last;
    logic [7:0]     pk_byte;
    logic [IW-1:0]  pk_idx;
    logic [8*BYTES-1:0] pk_word;

    assign fall = dl_q & ~ioctl_download;

    byte_packer #(
        .BYTES      (BYTES),
        .BIG_ENDIAN (BIG_ENDIAN),
        .PAD        (PAD)
    ) u_packer (
        .clk_i     (clk_sys),
        .reset_n_i (reset_n),
        .clear_i   (pk_clear),
        .load_i    (pk_load),
        .byte_i    (pk_byte),
        .pad_i     (pk_pad),
        .word_o    (pk_word),
        .idx_o     (pk_idx),
        .last_o    (pk_last)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        words_d  = words_q;
        ovf_d    = ovf_q;
        fin_d    = fin_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        pk_pad   = 1'b0;
        pk_byte  = rom_data;
        // Remember an end of download seen while a word is waiting on the target.
        if (src_q == SRC_IOCTL && fall) begin
            fin_d = 1'b1;
        end
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = (src_sel == SRC_IOCTL) ? IO_COLLECT : ROM_RD;
                    src_d    = src_e'(src_sel);
                    words_d  = '0;
                    ovf_d    = 1'b0;
                    fin_d    = 1'b0;
                    pk_clear = 1'b1;
                end else if (state_q == DONE && src_q == SRC_IOCTL && ioctl_download
                             && ioctl_wr && words_q == WORDS_W) begin
                    ovf_d = 1'b1;
                end
            end
            ROM_RD: begin
                state_d = ROM_CAP;
            end
            ROM_CAP: begin
                pk_load = 1'b1;
                state_d = pk_last ? WAIT_REQ : ROM_RD;
            end
            WAIT_REQ: begin
                if (tgt_req) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_q + (TAW+1)'(1);
                if (words_d == WORDS_W || (src_q == SRC_IOCTL && (fin_q || fall))) begin
                    state_d = DONE;
                end else begin
                    state_d = (src_q == SRC_IOCTL) ? IO_COLLECT : ROM_RD;
                end
            end
            IO_COLLECT: begin
                if (ioctl_wr) begin
                    pk_load = 1'b1;
                    pk_byte = ioctl_dout;
                end
                if (ioctl_wr && pk_last) begin
                    state_d = WAIT_REQ;
                end else if (fall) begin
                    if (ioctl_wr || pk_idx != '0) begin
                        pk_pad  = 1'b1;
                        state_d = IO_FLUSH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            IO_FLUSH: begin
                state_d = WAIT_REQ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= SRC_ROM;
            words_q <= '0;
            ovf_q   <= 1'b0;
            fin_q   <= 1'b0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
            fin_q   <= fin_d;
            dl_q    <= ioctl_download;
        end
    end

    assign rom_ce       = (state_q == ROM_RD);
    assign rom_addr     = RAW'(words_q[TAW-1:0]) * RAW'(BYTES) + RAW'(pk_idx);
    assign ioctl_wait   = (src_q == SRC_IOCTL) && (state_q == WAIT_REQ || state_q == WRITE);
    assign tgt_wr       = (state_q == WRITE);
    assign tgt_addr     = words_q[TAW-1:0];
    assign tgt_din      = pk_word;
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign loaded       = (state_q == DONE);
    assign overflow     = ovf_q;
    assign words_loaded = words_q;

`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Only real stream bytes reach pk_load; PAD lanes never enter the sum.
    always_comb begin
        csum_d = csum_q;
        if (pk_clear) begin
            csum_d = '0;
        end else if (pk_load) begin
            csum_d = csum_q + {8'h00, pk_byte};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum    = csum_q;
    assign csum_ok = loaded && (csum_q == csum_expect);
`endif

endmodule

// File: tb/tb_boot_rom_loader.sv
// tb/tb_boot_rom_loader.sv - directed self-checking bench for boot_rom_loader
module tb_boot_rom_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_to = 0;

    logic        rom_start = 1'b0;
    logic        w4_start = 1'b0;
    logic        ov_start = 1'b0;
    logic        w4_req = 1'b1;
    logic        io_dl = 1'b0;
    logic        io_wr = 1'b0;
    logic [7:0]  io_d = 8'h00;
    logic [15:0] cs_exp = 16'h001C;

    logic        le_ce, be_ce, w4_ce, ov_ce;
    logic [13:0] le_ra, be_ra, ov_ra;
    logic [14:0] w4_ra;
    logic [7:0]  le_rd = 8'h00;
    logic [7:0]  be_rd = 8'h00;
    logic        le_wait, be_wait, w4_wait, ov_wait;
    logic        le_wr, be_wr, w4_wr, ov_wr;
    logic [12:0] le_ta, be_ta, w4_ta, ov_ta;
    logic [15:0] le_td, be_td, ov_td;
    logic [31:0] w4_td;
    logic        le_busy, be_busy, w4_busy, ov_busy;
    logic        le_ld, be_ld, w4_ld, ov_ld;
    logic        le_ov, be_ov, w4_ov, ov_ov;
    logic [13:0] le_wl, be_wl, w4_wl, ov_wl;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    logic [15:0] le_cs, be_cs, w4_cs, ov_cs;
    logic        le_cok, be_cok, w4_cok, ov_cok;
`endif

    boot_rom_loader #(.BYTES(2), .TAW(13), .WORDS(4), .BIG_ENDIAN(1'b0), .PAD(8'hFF)) u_le (
        .clk_sys(clk), .reset_n(reset_n), .start(rom_start), .src_sel(1'b0),
        .rom_ce(le_ce), .rom_addr(le_ra), .rom_data(le_rd),
        .ioctl_download(1'b0), .ioctl_wr(1'b0), .ioctl_dout(8'h00), .ioctl_wait(le_wait),
        .tgt_req(1'b1), .tgt_wr(le_wr), .tgt_addr(le_ta), .tgt_din(le_td),
        .busy(le_busy), .loaded(le_ld), .overflow(le_ov), .words_loaded(le_wl)
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
        , .csum(le_cs), .csum_expect(cs_exp), .csum_ok(le_cok)
`endif
    );

    boot_rom_loader #(.BYTES(2), .TAW(13), .WORDS(4), .BIG_ENDIAN(1'b1), .PAD(8'hFF)) u_be (
        .clk_sys(clk), .reset_n(reset_n), .start(rom_start), .src_sel(1'b0),
        .rom_ce(be_ce), .rom_addr(be_ra), .rom_data(be_rd),
        .ioctl_download(1'b0), .ioctl_wr(1'b0), .ioctl_dout(8'h00), .ioctl_wait(be_wait),
        .tgt_req(1'b1), .tgt_wr(be_wr), .tgt_addr(be_ta), .tgt_din(be_td),
        .busy(be_busy), .loaded(be_ld), .overflow(be_ov), .words_loaded(be_wl)
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
        , .csum(be_cs), .csum_expect(cs_exp), .csum_ok(be_cok)
`endif
    );

    boot_rom_loader #(.BYTES(4), .TAW(13), .WORDS(8), .BIG_ENDIAN(1'b0), .PAD(8'hFF)) u_w4 (
        .clk_sys(clk), .reset_n(reset_n), .start(w4_start), .src_sel(1'b1),
        .rom_ce(w4_ce), .rom_addr(w4_ra), .rom_data(8'h00),
        .ioctl_download(io_dl), .ioctl_wr(io_wr), .ioctl_dout(io_d), .ioctl_wait(w4_wait),
        .tgt_req(w4_req), .tgt_wr(w4_wr), .tgt_addr(w4_ta), .tgt_din(w4_td),
        .busy(w4_busy), .loaded(w4_ld), .overflow(w4_ov), .words_loaded(w4_wl)
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
        , .csum(w4_cs), .csum_expect(cs_exp), .csum_ok(w4_cok)
`endif
    );

    boot_rom_loader #(.BYTES(2), .TAW(13), .WORDS(2), .BIG_ENDIAN(1'b0), .PAD(8'hFF)) u_ov (
        .clk_sys(clk), .reset_n(reset_n), .start(ov_start), .src_sel(1'b1),
        .rom_ce(ov_ce), .rom_addr(ov_ra), .rom_data(8'h00),
        .ioctl_download(io_dl), .ioctl_wr(io_wr), .ioctl_dout(io_d), .ioctl_wait(ov_wait),
        .tgt_req(1'b1), .tgt_wr(ov_wr), .tgt_addr(ov_ta), .tgt_din(ov_td),
        .busy(ov_busy), .loaded(ov_ld), .overflow(ov_ov), .words_loaded(ov_wl)
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
        , .csum(ov_cs), .csum_expect(cs_exp), .csum_ok(ov_cok)
`endif
    );

    // ROM contents: byte at address a is a[7:0], one cycle read latency.
    always @(posedge clk) begin
        if (le_ce) le_rd <= le_ra[7:0];
        if (be_ce) be_rd <= be_ra[7:0];
    end

    logic [63:0] le_log [16];
    logic [63:0] be_log [16];
    logic [63:0] w4_log [16];
    logic [63:0] ov_log [16];
    int le_n = 0, be_n = 0, w4_n = 0, ov_n = 0;

    always @(negedge clk) begin
        if (le_wr) begin if (le_n < 16) le_log[le_n] = 64'({le_ta, le_td}); le_n++; end
        if (be_wr) begin if (be_n < 16) be_log[be_n] = 64'({be_ta, be_td}); be_n++; end
        if (w4_wr) begin if (w4_n < 16) w4_log[w4_n] = 64'({w4_ta, w4_td}); w4_n++; end
        if (ov_wr) begin if (ov_n < 16) ov_log[ov_n] = 64'({ov_ta, ov_td}); ov_n++; end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return le_ld && be_ld;
            1:       return w4_ld;
            2:       return ov_ld;
            3:       return le_wl == 14'd2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input string tag);
        int k = 0;
        while (!cond(sel) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(cond(sel)), 64'd1);
    endtask

    task automatic pulse(input int sel);
        @(negedge clk);
        if (sel == 0) rom_start = 1'b1; else if (sel == 1) w4_start = 1'b1; else ov_start = 1'b1;
        @(negedge clk);
        rom_start = 1'b0; w4_start = 1'b0; ov_start = 1'b0;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while ((sel == 1 ? w4_wait : ov_wait) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) n_to++;
        io_d = b;
        io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    logic [63:0] exp_le [4] = '{64'h0_0100, 64'h1_0302, 64'h2_0504, 64'h3_0706};
    logic [63:0] exp_be [4] = '{64'h0_0001, 64'h1_0203, 64'h2_0405, 64'h3_0607};
    int b_le, b_be, b_w4, b_ov, n_ok;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_le", {le_busy, le_ld, le_ov, le_wr, le_ce, le_wait, le_wl, le_ta, le_td, le_ra}, 64'd0);
        check("rst_w4_flags", {w4_busy, w4_ld, w4_ov, w4_wr, w4_ce, w4_wait, w4_wl, w4_ta}, 64'd0);
        check("rst_w4_din", 64'(w4_td), 64'd0);
        reset_n = 1'b1;

        // ROM mode, little and big endian loads in parallel
        b_le = le_n; b_be = be_n;
        pulse(0);
        wait_cond(0, "rom_done");
        repeat (5) @(negedge clk);
        check("le_nwr", 64'(le_n - b_le), 64'd4);
        check("be_nwr", 64'(be_n - b_be), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("le_w%0d", i), le_log[b_le+i], exp_le[i]);
            check($sformatf("be_w%0d", i), be_log[b_be+i], exp_be[i]);
        end
        check("le_wl", 64'(le_wl), 64'd4);
        check("le_flags", {le_ld, le_busy, le_ov}, 3'b100);
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
        check("le_csum", 64'(le_cs), 64'h001C);
        check("le_csum_ok", 64'(le_cok), 64'd1);
`endif

        // one-cycle reset at word 2, then a fresh load from address 0
        pulse(0);
        wait_cond(3, "rom_word2");
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check("rst2_le", {le_busy, le_ld, le_ov, le_wr, le_ce, le_wait, le_wl, le_ta, le_td, le_ra}, 64'd0);
        b_le = le_n;
        pulse(0);
        wait_cond(0, "reload_done");
        check("reload_nwr", 64'(le_n - b_le), 64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("reload_w%0d", i), le_log[b_le+i], exp_le[i]);
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
        check("reload_csum", 64'(le_cs), 64'h001C);
`endif

        // ioctl, 4-byte words, 6 bytes then end of download with a partial word
        b_w4 = w4_n; w4_req = 1'b1;
        pulse(1);
        @(negedge clk); io_dl = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(1, 8'hAA + 8'(i * 17));
        @(negedge clk); io_dl = 1'b0;
        wait_cond(1, "w4_done");
        check("w4_nwr", 64'(w4_n - b_w4), 64'd2);
        check("w4_w0", w4_log[b_w4], 64'h0_DDCCBBAA);
        check("w4_w1", w4_log[b_w4+1], 64'h1_FFFFFFEE);
        check("w4_wl", 64'(w4_wl), 64'd2);
        check("w4_ovf", 64'(w4_ov), 64'd0);

        // target stall mid-ioctl, with a stray byte sent against ioctl_wait
        b_w4 = w4_n; w4_req = 1'b0;
        pulse(1);
        @(negedge clk); io_dl = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(1, 8'h11 * 8'(i + 1));
        @(negedge clk); io_d = 8'h99; io_wr = 1'b1;
        n_ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            io_wr = 1'b0;
            if (w4_wait && w4_td == 32'h44332211 && !w4_wr) n_ok++;
        end
        check("stall_hold", 64'(n_ok), 64'd20);
        w4_req = 1'b1;
        @(negedge clk); check("release_wr", {w4_wr, w4_wait}, 2'b11);
        @(negedge clk); check("release_drop", {w4_wr, w4_wait}, 2'b00);
        check("stall_nwr", 64'(w4_n - b_w4), 64'd1);
        @(negedge clk); io_dl = 1'b0;
        wait_cond(1, "stall_done");
        check("stall_wl", 64'(w4_wl), 64'd1);
        check("stall_word", w4_log[b_w4], 64'h0_44332211);

        // ioctl overflow: WORDS=2, six bytes sent
        b_ov = ov_n;
        pulse(2);
        @(negedge clk); io_dl = 1'b1;
        for (int i = 1; i <= 6; i++) send_byte(2, 8'(i));
        @(negedge clk); io_dl = 1'b0;
        repeat (4) @(negedge clk);
        check("ov_nwr", 64'(ov_n - b_ov), 64'd2);
        check("ov_w0", ov_log[b_ov], 64'h0_0201);
        check("ov_w1", ov_log[b_ov+1], 64'h1_0403);
        check("ov_flags", {ov_ov, ov_ld, ov_wait, ov_busy}, 4'b1100);
        check("ov_wl", 64'(ov_wl), 64'd2);
        check("w4_no_ovf", 64'(w4_ov), 64'd0);
        check("wait_timeouts", 64'(n_to), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/boot_rom_loader.md
Name: boot_rom_loader

Overview:
- Parametrised successor to the single-purpose 8-bit-ROM-to-16-bit BIOS copy logic in the top level.
- Assembles a byte stream into BYTES-wide little- or big-endian words and writes them into the system BIOS shadow through the req/wr handshake.
- The byte stream comes from either an internal byte ROM or the HPS ioctl download.
- Sits between hps_io/rom and the system core; drives the core-reset hold-off via loaded.

Parameters:
- BYTES, 2, bytes per target word (1..4).
- TAW, 13, target word-address width.
- WORDS, 8192, words copied in ROM mode; max words accepted in ioctl mode (≤ 2^TAW).
- BIG_ENDIAN, 0, 0: first byte lands in tgt_din[7:0]; 1: first byte lands in the MSB.
- PAD, 8'hFF, fill byte for a partial final word in ioctl mode.

Ports:
- clk_sys  in  1  system clock; everything is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- src_sel  in  1  sampled at start; 0 = ROM, 1 = ioctl.
- rom_ce  out  1  ROM read enable.
- rom_addr  out  TAW+$clog2(BYTES)  ROM byte address.
- rom_data  in  8  ROM data, valid 1 cycle after rom_ce.
- ioctl_download  in  1  HPS download active.
- ioctl_wr  in  1  byte strobe.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  back-pressure to HPS.
- tgt_req  in  1  target ready for a word.
- tgt_wr  out  1  one-cycle write strobe.
- tgt_addr  out  TAW  target word address.
- tgt_din  out  8*BYTES  assembled word.
- busy  out  1  load in progress.
- loaded  out  1  sticky completion flag.
- overflow  out  1  sticky; ioctl sent more than WORDS words.
- words_loaded  out  TAW+1  number of words written.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index and word counter 0.
- reset_n low in any state aborts immediately and clears loaded and overflow.
- FSM states: IDLE, ROM_RD, ROM_CAP, WAIT_REQ, WRITE, IO_COLLECT, IO_FLUSH, DONE.
- IDLE:
  - start pulse → busy=1, loaded=0, overflow=0, counters cleared.
  - src_sel=0 → ROM_RD; src_sel=1 → IO_COLLECT.
  - start in any other state is ignored.
- ROM_RD: rom_ce=1, rom_addr = word*BYTES + byte index; go to ROM_CAP.
- ROM_CAP:
  - Capture rom_data into the lane for the current byte index (lane order per BIG_ENDIAN).
  - If the word is incomplete, increment the index and return to ROM_RD.
  - If the word is complete, go to WAIT_REQ.
  - Throughput: 2 cycles per byte plus the handshake.
- WAIT_REQ:
  - Hold tgt_addr/tgt_din stable.
  - On tgt_req=1 go to WRITE.
  - No timeout; a stalled target stalls the loader.
- WRITE:
  - tgt_wr=1 for exactly one cycle; then increment words_loaded and tgt_addr.
  - If words_loaded == WORDS → DONE.
  - Else return to ROM_RD (ROM mode) or IO_COLLECT (ioctl mode).
- IO_COLLECT:
  - On ioctl_wr, store ioctl_dout into the current lane; when the word completes go to WAIT_REQ.
  - ioctl_wait is 1 in WAIT_REQ and WRITE while in ioctl mode, 0 otherwise; bytes arriving while ioctl_wait=1 are a protocol violation and are dropped.
  - On the falling edge of ioctl_download with a partial word, fill the remaining lanes with PAD and go to IO_FLUSH → WAIT_REQ → WRITE → DONE.
  - On the falling edge with index 0 → DONE.
- Overflow: once words_loaded == WORDS in ioctl mode, the FSM enters DONE.
  - Further ioctl_wr bytes while ioctl_download=1 set overflow=1 and are discarded.
  - ioctl_wait stays 0.
- DONE: loaded=1, busy=0. A new start restarts the load.
- tgt_addr wraps modulo 2^TAW. With WORDS = 2^TAW the final write goes to address all-ones and the load stops, so no wrap write occurs.
- If ioctl_wr and the ioctl_download fall occur in the same cycle, the byte is stored first, then the padding rule applies.

Optional Feature:
- Macro: BOOT_ROM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Adds output csum[15:0], a modulo-2^16 sum of every byte accepted (PAD bytes excluded).
  - The sum is cleared at start and frozen at DONE.
  - Adds input csum_expect[15:0] and output csum_ok = loaded && csum == csum_expect.
- Without the macro: neither port exists, and there is no adder logic.

Decomposition:
- Package boot_loader_pkg holds:
  - the state enum;
  - a SRC_ROM/SRC_IOCTL enum;
  - a function for lane index from byte index and BIG_ENDIAN.
- One natural sub-module, byte_packer: lane shift/insert, byte index counter and PAD fill. The top holds the FSM and handshake.

Test Plan:
- ROM mode, BYTES=2, WORDS=4, ROM = 00..07, tgt_req always 1:
  - writes (0,16'h0100), (1,16'h0302), (2,16'h0504), (3,16'h0706);
  - loaded=1 and words_loaded=4;
  - tgt_wr high exactly 4 cycles.
- Same load with BIG_ENDIAN=1: words 16'h0001, 16'h0203, 16'h0405, 16'h0607.
- ioctl mode, BYTES=4, 6 bytes AA..F:
  - writes 32'hDDCCBBAA at address 0 and 32'hFFFFFFEE... i.e. bytes EE,FF plus PAD,PAD = 32'hFFFFFFEE at address 1;
  - words_loaded=2.
- tgt_req held 0 for 20 cycles mid-ioctl:
  - ioctl_wait=1 throughout and tgt_din stable;
  - on release, one tgt_wr and ioctl_wait drops the next cycle.
- ioctl, WORDS=2, BYTES=2, 6 bytes sent: two writes, overflow=1, loaded=1, and no third tgt_wr.
- reset_n low for 1 cycle mid-ROM load at word 2:
  - all outputs 0;
  - a subsequent start reloads from address 0.
  - With BOOT_ROM_LOADER_CHECKSUM_EN, bytes 00..07 give csum=16'h001C and csum_ok=1 when csum_expect=16'h001C.
